seq_divider: RTL and testbench

//  Sequential unsigned shift-subtract divider, the inverse of the shift-add multiplier.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 167 ++++++++++++++++
 tb/tb_seq_divider.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand/result bundle between the control unit and the
// sequential divider. The master side (control unit) requests a divide and
// collects the result. The slave side (the divider) performs it.
interface seq_divider_if #(
  parameter int W = 8
) ();
  logic         St;
  logic [W-1:0] Dvd;
  logic [W-1:0] Dvs;
  logic [W-1:0] Quo;
  logic [W-1:0] Rem;
  logic         Busy;
  logic         Done;
  logic         DivZ;

  modport master (
    output St, Dvd, Dvs,
    input  Quo, Rem, Busy, Done, DivZ
  );

  modport slave (
    input  St, Dvd, Dvs,
    output Quo, Rem, Busy, Done, DivZ
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring shift-subtract divider.
// Each quotient bit takes two clocks: a shift of {R,Q} followed by a trial subtract.
// A divide-by-zero request bypasses the iteration. It completes with
// Quo=all-ones, Rem=Dvd and DivZ=1.
// Optional feature macro: DIV_SIGNED_EN enables two's-complement operands.
// The iteration runs on magnitudes, and the sign is fixed up when the result
// is loaded into Quo/Rem. Without the macro the divider is purely unsigned.
module seq_divider #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SH,
    S_SUB,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       r_q, r_d;
  logic [W-1:0]       q_q, q_d;
  logic [W-1:0]       d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       quo_q, quo_d;
  logic [W-1:0]       rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;
  logic [W:0]         diff;

`ifdef DIV_SIGNED_EN
  logic               sdvd_q, sdvd_d;
  logic               sdvs_q, sdvs_d;
`endif

  // Next-state and datapath computation for the controller and the R/Q/D registers
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    divz_d  = divz_q;
`ifdef DIV_SIGNED_EN
    sdvd_d  = sdvd_q;
    sdvs_d  = sdvs_q;
`endif
    // The trial subtract uses one extra bit. The top bit of diff is the borrow,
    // so it is set exactly when R < D.
    diff = {1'b0, r_q} - {1'b0, d_q};

    case (state_q)
      S_IDLE: begin
        if (bus.St) begin
          if (bus.Dvs != '0) begin
            r_d     = '0;
            cnt_d   = '0;
            state_d = S_SH;
`ifdef DIV_SIGNED_EN
            sdvd_d  = bus.Dvd[W-1];
            sdvs_d  = bus.Dvs[W-1];
            q_d     = bus.Dvd[W-1] ? -bus.Dvd : bus.Dvd;
            d_d     = bus.Dvs[W-1] ? -bus.Dvs : bus.Dvs;
`else
            q_d     = bus.Dvd;
            d_d     = bus.Dvs;
`endif
          end else begin
            quo_d   = '1;
            rem_d   = bus.Dvd;
            divz_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_SH: begin
        // The partial remainder stays below the current dividend prefix,
        // so the bit that falls off the top of R here is always zero.
        {r_d, q_d} = {r_q[W-2:0], q_q, 1'b0};
        state_d    = S_SUB;
      end

      S_SUB: begin
        if (!diff[W]) begin
          r_d = diff[W-1:0];
          q_d = {q_q[W-1:1], 1'b1};
        end
        if (cnt_q == CNT_W'(W - 1)) begin
`ifdef DIV_SIGNED_EN
          quo_d = (sdvd_q ^ sdvs_q) ? -q_d : q_d;
          rem_d = sdvd_q ? -r_d : r_d;
`else
          quo_d = q_d;
          rem_d = r_d;
`endif
          divz_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_SH;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Busy and Done come from the next state, so as registers they follow the current state
    busy_d = (state_d == S_SH) || (state_d == S_SUB);
    done_d = (state_d == S_FIN);
  end

  // State and datapath registers; asynchronous reset aborts any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      sdvd_q  <= 1'b0;
      sdvs_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
`ifdef DIV_SIGNED_EN
      sdvd_q  <= sdvd_d;
      sdvs_q  <= sdvs_d;
`endif
    end
  end

  assign bus.Quo  = quo_q;
  assign bus.Rem  = rem_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.DivZ = divz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed self-checking bench for seq_divider.
// Expected results come from plain integer division and remainder.
module tb_seq_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer division (truncating toward zero), plus the divide-by-zero rule
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
`ifdef DIV_SIGNED_EN
    int sa, sb;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           cyc, busy_cnt;
    model(a, b, eq, er, ez);
    @(negedge clk);
    bus.St  = 1'b1;
    bus.Dvd = a;
    bus.Dvs = b;
    @(negedge clk);
    bus.St  = 1'b0;
    bus.Dvd = W'($urandom);
    bus.Dvs = W'($urandom);
    cyc = 1;
    busy_cnt = 0;
    while (!bus.Done && cyc < 60) begin
      busy_cnt += int'(bus.Busy);
      @(negedge clk);
      cyc++;
    end
    check({tag, " done"}, bus.Done, 1);
    check({tag, " busy@done"}, bus.Busy, 0);
    if (b == '0) begin
      check({tag, " z-latency<=2"}, (cyc <= 2), 1);
      check({tag, " z-busy"}, busy_cnt, 0);
    end else begin
      check({tag, " latency"}, cyc, 2 * W + 1);
      check({tag, " busy cycles"}, busy_cnt, 2 * W);
    end
    check({tag, " quo"}, bus.Quo, eq);
    check({tag, " rem"}, bus.Rem, er);
    check({tag, " divz"}, bus.DivZ, ez);
    @(negedge clk);
    check({tag, " done pulse"}, bus.Done, 0);
    check({tag, " idle busy"}, bus.Busy, 0);
    check({tag, " quo hold"}, bus.Quo, eq);
  endtask

  initial begin
    logic [W-1:0] eq, er, a, b;
    logic         ez;
    int           cyc, done_seen;

    rst     = 1'b1;
    bus.St  = 1'b0;
    bus.Dvd = '0;
    bus.Dvs = '0;
    #12;
    check("reset quo", bus.Quo, 0);
    check("reset rem", bus.Rem, 0);
    check("reset busy", bus.Busy, 0);
    check("reset done", bus.Done, 0);
    check("reset divz", bus.DivZ, 0);
    @(negedge clk);
    rst = 1'b0;

    run_div(8'd100, 8'd7,   "100/7");
    run_div(8'd255, 8'd1,   "255/1");
    run_div(8'd5,   8'd9,   "5/9");
    run_div(8'd200, 8'd200, "200/200");
    run_div(8'd42,  8'd0,   "42/0");
    run_div(8'd9,   8'd3,   "9/3");
`ifdef DIV_SIGNED_EN
    run_div(8'h9C, 8'd7,  "-100/7");
    run_div(8'd100, 8'hF9, "100/-7");
    run_div(8'h80, 8'hFF, "-128/-1");
    run_div(8'h80, 8'h00, "-128/0");
`endif

    // Random operands, with a zero divisor roughly one time in eight
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_div(a, b, "rand");
    end

    // St held high throughout the run, with Dvd changed mid-run. Back-to-back start after FIN.
    @(negedge clk);
    bus.St  = 1'b1;
    bus.Dvd = 8'd100;
    bus.Dvs = 8'd7;
    cyc = 0;
    while (!bus.Done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) bus.Dvd = 8'd50;
    end
    model(8'd100, 8'd7, eq, er, ez);
    check("held done", bus.Done, 1);
    check("held quo", bus.Quo, eq);
    check("held rem", bus.Rem, er);
    bus.Dvd = 8'd9;
    bus.Dvs = 8'd3;
    @(negedge clk);
    check("post-fin idle busy", bus.Busy, 0);
    check("post-fin idle done", bus.Done, 0);
    @(negedge clk);
    bus.St = 1'b0;
    check("b2b started", bus.Busy, 1);
    cyc = 1;
    while (!bus.Done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    model(8'd9, 8'd3, eq, er, ez);
    check("b2b latency", cyc, 2 * W + 1);
    check("b2b quo", bus.Quo, eq);
    check("b2b rem", bus.Rem, er);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    bus.St  = 1'b1;
    bus.Dvd = 8'd100;
    bus.Dvs = 8'd7;
    @(negedge clk);
    bus.St = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst quo", bus.Quo, 0);
    check("arst rem", bus.Rem, 0);
    check("arst busy", bus.Busy, 0);
    check("arst done", bus.Done, 0);
    check("arst divz", bus.DivZ, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_seen += int'(bus.Done) + int'(bus.Busy);
    end
    check("post-reset quiet", done_seen, 0);
    run_div(8'd77, 8'd5, "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
